// File: rtl/lane_pkg.sv
// Shared types, lane colour table and dimming helper for the lane highlighter.
package lane_pkg;

  typedef logic [5:0] rgb_t;

  localparam rgb_t GREEN  = 6'b001100;
  localparam rgb_t RED    = 6'b110000;
  localparam rgb_t YELLOW = 6'b111100;
  localparam rgb_t BLUE   = 6'b000011;
  localparam rgb_t WHITE  = 6'b111111;

  localparam rgb_t LANE_COLOURS [8] = '{GREEN, RED, YELLOW, BLUE, GREEN, RED, YELLOW, BLUE};

  // Any channel with its MSB set drops to level 1; levels 0 and 1 pass through.
  function automatic rgb_t dim(rgb_t c);
    rgb_t d;
    d = c;
    for (int k = 0; k < 3; k++) begin
      if (c[2*k+1]) d[2*k +: 2] = 2'b01;
    end
    return d;
  endfunction

endpackage

// File: rtl/lane_highlighter_if.sv
// Pixel-stream bus for the lane highlighter: VGA position/valid and hits in, colour/state out.
interface lane_highlighter_if
  import lane_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4
) ();

  logic [9:0]           col;
  logic [9:0]           row;
  logic                 valid;
  logic [NUM_LANES-1:0] hit;
  rgb_t                 lane_rgb;
  logic [NUM_LANES-1:0] active;

  modport master (
    output col, row, valid, hit,
    input  lane_rgb, active
  );

  modport slave (
    input  col, row, valid, hit,
    output lane_rgb, active
  );

endinterface

// File: rtl/lane_timer.sv
// Per-lane hit edge detector and frame-based hold counter; active is high while the hold runs.
module lane_timer #(
  parameter int unsigned HOLD_FRAMES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  input  logic frame_tick,
  output logic active
);

  localparam int unsigned CntW = $clog2(HOLD_FRAMES + 1);

  logic            hit_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q;

  // A fresh hit reloads even on a frame tick, so a re-hit never leaves a dark gap.
  always_comb begin
    cnt_d = cnt_q;
    if (hit && !hit_q) begin
      cnt_d = CntW'(HOLD_FRAMES);
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      hit_q    <= hit;
      cnt_q    <= cnt_d;
      active_q <= (cnt_d != '0);
    end
  end

  assign active = active_q;

endmodule

// File: rtl/lane_highlighter.sv
// Draws coloured lane stripes into the VGA stream, bright for a few frames after a hit.
// Optional LANE_DIVIDER_EN: paint lane boundary columns white instead of black.
module lane_highlighter
  import lane_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned LANE_BEGIN   = 220,
  parameter int unsigned LANE_PITCH   = 40,
  parameter int unsigned STRIPE_WIDTH = 35,
  parameter int unsigned HOLD_FRAMES  = 3,
  parameter int unsigned V_ACTIVE     = 480
) (
  input  logic             clk,
  input  logic             reset,
  lane_highlighter_if.slave bus
);

  localparam logic [10:0] LastRight =
      11'(LANE_BEGIN + (NUM_LANES - 1) * LANE_PITCH + STRIPE_WIDTH);

  logic [9:0]           row_q;
  logic                 frame_tick;
  logic [10:0]          col_x;
  logic [NUM_LANES-1:0] active_w;
  logic [NUM_LANES-1:0] fill;
  logic [NUM_LANES-1:0] on_left;
  logic                 on_divider;
  rgb_t                 colour [NUM_LANES];
  rgb_t                 pix_d, rgb_q;

  assign col_x      = {1'b0, bus.col};
  assign frame_tick = (bus.row == 10'(V_ACTIVE)) && (row_q != 10'(V_ACTIVE));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [10:0] Left  = 11'(LANE_BEGIN + i * LANE_PITCH);
    localparam logic [10:0] Right = 11'(LANE_BEGIN + i * LANE_PITCH + STRIPE_WIDTH);

    assign fill[i]    = (col_x > Left) && (col_x < Right);
    assign on_left[i] = (col_x == Left);
    assign colour[i]  = active_w[i] ? LANE_COLOURS[i] : dim(LANE_COLOURS[i]);

    lane_timer #(
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .hit       (bus.hit[i]),
      .frame_tick(frame_tick),
      .active    (active_w[i])
    );
  end

  assign on_divider = (|on_left) || (col_x == LastRight);

  // Descending scan so the lowest-indexed overlapping lane is the last writer.
  always_comb begin
    pix_d = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (fill[i]) pix_d = colour[i];
    end
    if (on_divider) begin
`ifdef LANE_DIVIDER_EN
      pix_d = WHITE;
`else
      pix_d = '0;
`endif
    end
    if (!bus.valid) pix_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      rgb_q <= '0;
    end else begin
      row_q <= bus.row;
      rgb_q <= pix_d;
    end
  end

  assign bus.lane_rgb = rgb_q;
  assign bus.active   = active_w;

endmodule

// File: tb/tb_lane_highlighter.sv
// Scoreboard bench for lane_highlighter: expected pixels queued at drive time, popped one cycle on.
module tb_lane_highlighter;
  import lane_pkg::*;

  localparam int unsigned NL = 4;

  logic clk = 1'b0;
  logic reset;

  lane_highlighter_if #(.NUM_LANES(NL)) bus ();

  lane_highlighter #(
    .NUM_LANES(NL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  exp_q [$];
  int          m_cnt [NL];
  logic [NL-1:0] m_hit_q;
  logic [9:0]  m_row_q;
  logic [NL-1:0] m_act;

`ifdef LANE_DIVIDER_EN
  localparam logic [5:0] DivExp = 6'b111111;
`else
  localparam logic [5:0] DivExp = 6'b000000;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_pixel(input logic [9:0] c, input logic v,
                                           input logic [NL-1:0] act);
    logic [5:0] bright [4];
    logic [5:0] dimc [4];
    int cc;
    bright = '{6'b001100, 6'b110000, 6'b111100, 6'b000011};
    dimc   = '{6'b000100, 6'b010000, 6'b010100, 6'b000001};
    cc = int'(c);
    if (!v) return 6'b0;
    for (int i = 0; i < NL; i++) if (cc == 220 + 40 * i) return DivExp;
    if (cc == 220 + 40 * (NL - 1) + 35) return DivExp;
    for (int i = 0; i < NL; i++) begin
      if (cc > 220 + 40 * i && cc < 255 + 40 * i) return act[i] ? bright[i % 4] : dimc[i % 4];
    end
    return 6'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_hit_q = '0;
    m_row_q = '0;
    m_act   = '0;
  endtask

  // want < 0: expected pixel comes from the reference model.
  task automatic step(input int c, input int r, input logic v, input logic [NL-1:0] h,
                      input int want, input string tag);
    logic tick;
    bus.col   = 10'(c);
    bus.row   = 10'(r);
    bus.valid = v;
    bus.hit   = h;
    exp_q.push_back(want < 0 ? ref_pixel(10'(c), v, m_act) : 6'(want));
    @(posedge clk);
    tick = (r == 480) && (m_row_q != 10'd480);
    for (int i = 0; i < NL; i++) begin
      if (h[i] && !m_hit_q[i]) m_cnt[i] = 3;
      else if (tick && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
      m_act[i] = (m_cnt[i] != 0);
    end
    m_hit_q = h;
    m_row_q = 10'(r);
    #1;
    check_eq({tag, "_rgb"}, 32'(bus.lane_rgb), 32'(exp_q.pop_front()));
    check_eq({tag, "_act"}, 32'(bus.active), 32'(m_act));
  endtask

  initial begin
    bus.col   = '0;
    bus.row   = '0;
    bus.valid = 1'b0;
    bus.hit   = '0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rgb", 32'(bus.lane_rgb), 32'd0);
    check_eq("reset_act", 32'(bus.active), 32'd0);
    reset = 1'b0;

    // 1: idle stripes and boundaries
    step(220, 100, 1'b1, 4'b0000, int'(DivExp), "t1_c220");
    step(221, 100, 1'b1, 4'b0000, 6'b000100, "t1_c221");
    step(254, 100, 1'b1, 4'b0000, 6'b000100, "t1_c254");
    step(255, 100, 1'b1, 4'b0000, 6'b000000, "t1_c255");
    step(261, 100, 1'b1, 4'b0000, 6'b010000, "t1_c261");

    // 2: single-cycle hit on lane 0, bright through two ticks, dark after third
    step(230, 100, 1'b1, 4'b0001, 6'b000100, "t2_hit");
    step(230, 100, 1'b1, 4'b0000, 6'b001100, "t2_bright");
    for (int f = 0; f < 3; f++) begin
      step(230, 480, 1'b1, 4'b0000, -1, "t2_tick");
      step(230, 100, 1'b1, 4'b0000, -1, "t2_line");
    end
    check_eq("t2_act0_off", 32'(bus.active[0]), 32'd0);
    step(230, 100, 1'b1, 4'b0000, 6'b000100, "t2_dim");

    // 3: hit held high for ten frames loads only once
    for (int f = 0; f < 10; f++) begin
      step(310, 100, 1'b1, 4'b0100, -1, "t3_line");
      step(310, 480, 1'b1, 4'b0100, -1, "t3_tick");
    end
    check_eq("t3_act2_off", 32'(bus.active[2]), 32'd0);
    step(310, 100, 1'b1, 4'b0000, 6'b010100, "t3_dim");

    // 4: re-hit on the tick that would take the counter from 1 to 0
    step(270, 100, 1'b1, 4'b0010, -1, "t4_load");
    step(270, 480, 1'b1, 4'b0010, -1, "t4_tick1");
    step(270, 100, 1'b1, 4'b0000, -1, "t4_line");
    step(270, 480, 1'b1, 4'b0000, -1, "t4_tick2");
    step(270, 100, 1'b1, 4'b0000, -1, "t4_line");
    step(270, 480, 1'b1, 4'b0010, 6'b110000, "t4_rehit");
    check_eq("t4_nogap", 32'(bus.active[1]), 32'd1);
    for (int f = 0; f < 3; f++) begin
      step(270, 100, 1'b1, 4'b0000, -1, "t4_line");
      step(270, 480, 1'b1, 4'b0000, -1, "t4_tick");
    end
    check_eq("t4_act1_off", 32'(bus.active[1]), 32'd0);

    // 5: blanking and asynchronous mid-frame reset
    step(230, 100, 1'b1, 4'b0001, -1, "t5_hit");
    step(230, 100, 1'b0, 4'b0000, 6'b000000, "t5_blank");
    step(230, 100, 1'b1, 4'b1111, -1, "t5_all");
    step(350, 100, 1'b1, 4'b1111, 6'b000011, "t5_blue");
    check_eq("t5_all_act", 32'(bus.active), 32'hf);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_rgb", 32'(bus.lane_rgb), 32'd0);
    check_eq("t5_rst_act", 32'(bus.active), 32'd0);
    bus.hit = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 6: divider columns
    step(220, 100, 1'b1, 4'b0000, int'(DivExp), "t6_c220");
    step(375, 100, 1'b1, 4'b0000, int'(DivExp), "t6_c375");
    step(300, 100, 1'b1, 4'b0000, int'(DivExp), "t6_c300");

    // Randomised traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      step(int'($urandom_range(210, 390)), ($urandom_range(0, 3) == 0) ? 480 : 100,
           1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           -1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
